// File: rtl/instr_prefetch_buffer.sv
`timescale 1ns/1ps
// instr_prefetch_buffer
// Fetch-stage prefetch queue between the PC generator and decode. Issues
// sequential reads to a synchronous-read instruction memory (data one cycle
// after the request), buffers {PC, instr} pairs in a DEPTH-entry FIFO and
// presents the head to decode. Stall holds the head; redirect flushes all
// buffered and in-flight fetches and restarts fetch at a new PC.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   stall_en_i     decode not accepting; head held
//   redirect_en_i  flush and restart (priority over stall)
//   redirect_pc_i  restart address, low two bits ignored
//   imem_req_o     read issued this cycle
//   imem_addr_o    read address (fetch PC)
//   imem_data_i    read data, valid one cycle after imem_req_o
//   instr_d_o      head instruction, NOP_INSTR when nothing valid
//   pc_d_o         head PC, 0 when nothing valid
//   valid_d_o      head valid
//   count_o        occupied FIFO entries
module instr_prefetch_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          stall_en_i,
  input  logic          redirect_en_i,
  input  logic [31:0]   redirect_pc_i,
  output logic          imem_req_o,
  output logic [31:0]   imem_addr_o,
  input  logic [31:0]   imem_data_i,
  output logic [31:0]   instr_d_o,
  output logic [31:0]   pc_d_o,
  output logic          valid_d_o,
  output logic [CW-1:0] count_o
);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          pending_q, pending_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  logic [CW:0] inflight;
  logic        issue;
  logic        push;
  logic        pop;
  logic        valid;

  // A credit is an empty slot not already claimed by an outstanding read.
  // count_q is the registered occupancy, so a pop frees its slot only on the
  // following cycle.
  assign inflight = {1'b0, count_q} + (CW+1)'(pending_q);
  assign issue    = rst_ni && !redirect_en_i && (inflight < (CW+1)'(DEPTH));
  assign valid    = (count_q != '0) && !redirect_en_i;
  // A return during a redirect cycle belongs to the old stream: drop it.
  assign push     = pending_q && !redirect_en_i;
  assign pop      = valid && !stall_en_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    pending_d  = pending_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (redirect_en_i) begin
      fetch_pc_d = redirect_pc_i & 32'hFFFF_FFFC;
      pending_d  = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      pending_d = issue;
      if (issue) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      pending_q  <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      pending_q  <= pending_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage needs no reset: Count gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= req_pc_q;
      instr_mem[wr_ptr_q] <= imem_data_i;
    end
  end

  assign imem_req_o  = issue;
  assign imem_addr_o = fetch_pc_q;
  assign valid_d_o   = valid;
  assign instr_d_o   = valid ? instr_mem[rd_ptr_q] : NOP_INSTR;
  assign pc_d_o      = valid ? pc_mem[rd_ptr_q] : 32'h0000_0000;
  assign count_o     = count_q;

endmodule
